multi_channel_clock_divider: RTL
================================

Name: multi_channel_clock_divider

Overview:
- Parametrised successor to the single fixed-ratio divider: NUM_CH independent channels, each with a run-time programmable half-period.
- Each channel has a gated enable, glitch-free ratio change and disable, a one-cycle rising-edge tick, and a global phase-align strobe.
- Sits between the board clock and slow consumers (display scan, debouncers, audio/timing logic) as the design's single low-speed clock/tick source.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 16, width of the half-period and counter registers.
- DEFAULT_HALF, 8001, half-period loaded into every channel at reset; equals the legacy fixed ratio.
- SEL_W, 2, width of divSel; must satisfy 2**SEL_W >= NUM_CH.

Ports:
- inClk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, asynchronous active-high reset.
- enable, input, NUM_CH, per-channel run enable, level-sensitive.
- divLoad, input, 1, single-cycle strobe that writes divValue into channel divSel's pending register.
- divSel, input, SEL_W, channel index for divLoad.
- divValue, input, CNT_W, new half-period in inClk cycles.
- phaseSync, input, 1, single-cycle strobe that restarts all running channels in phase.
- outClk, output, NUM_CH, divided clocks, registered.
- tick, output, NUM_CH, one-inClk-cycle pulse coincident with each outClk 0->1 transition.
- running, output, NUM_CH, high while the channel is actively dividing.

Behaviour:
- Reset (async, reset=1): every counter=0, half=pending=DEFAULT_HALF, outClk=0, tick=0, running=0. Outputs stay at these values until reset is released.
- Effective half-period H = half, with half=0 treated as 1. When running, outClk toggles every H inClk cycles: period 2H, 50% duty.
- Counter: counts 0..H-1. On the cycle where counter==H-1:
  - outClk toggles and counter returns to 0;
  - if outClk was 0, tick=1 for that cycle, registered together with outClk;
  - half <= pending, so a new ratio only takes effect at a toggle boundary. This is glitch-free; no partial phase is ever shortened.
- Channel states: IDLE, RUN, STOPPING.
  - IDLE: outClk=0, counter=0, running=0. enable=1 -> RUN on the next cycle, with half<=pending. The first toggle (0->1, with tick) occurs H cycles after running rises.
  - RUN: running=1. enable=0 while outClk=1 -> STOPPING. enable=0 while outClk=0 -> IDLE immediately, with counter cleared.
  - STOPPING: running=1; counts out the current high phase. At the terminal count outClk->0 and the channel goes to IDLE. enable returning to 1 during STOPPING -> back to RUN with no disturbance.
- divLoad: pending[divSel] <= divValue. divSel >= NUM_CH is ignored. If the channel is IDLE, half is also updated immediately.
  - A load on the same cycle as that channel's terminal count: the terminal count uses the old pending value, and the new value is applied at the next boundary.
  - Back-to-back loads: the last one wins.
- phaseSync: every channel in RUN or STOPPING sets counter=0 and outClk=0 with no tick. STOPPING channels go to IDLE. half<=pending.
  - phaseSync has priority over a terminal count on the same cycle.
  - IDLE channels are unaffected.
- The counter never exceeds H-1. A half reduced below the current count cannot occur, because half changes only at count 0.
- Width: CNT_W-bit unsigned compare; no wrap-around is possible.

Decomposition:
- Shared package: channel state encoding (IDLE=2'd0, RUN=2'd1, STOPPING=2'd2) and the DEFAULT_HALF constant.
- Sub-module clk_div_channel holds counter, half, pending, state, outClk and tick. The top level instantiates NUM_CH copies via generate and decodes divLoad/divSel.

Test Plan:
- Reset release, enable[0]=1, default half=8001 -> running[0] high next cycle; outClk[0] rises 8001 cycles later with one tick; period is 16002 cycles.
- divLoad sel=1 value=3 while IDLE, then enable[1]=1 -> outClk[1] period 6, duty 3/3; tick[1] is one cycle wide every 6 cycles.
- Channel 2 running half=5; divLoad value=2 mid-phase -> the current phase completes at 5 cycles, and subsequent phases are 2 cycles each.
- Channel 3 half=4, drop enable while outClk=1 -> high phase completes (4 cycles total), outClk=0, running=0. Drop enable while outClk=0 -> running=0 on the next cycle, with no extra edge.
- Channels 0 and 1 running half=3 and 7, pulse phaseSync -> both outClk=0 and counters 0 the next cycle; both rise together 3 or 7 cycles later respectively. phaseSync coincident with a terminal count -> sync wins, no tick.
- Assert reset mid-run (asynchronously, between clock edges) -> outClk, tick and running go to 0 immediately. half=0 loaded -> behaves as half=1 (period 2).

Source files
------------

// File: rtl/multi_channel_clock_divider_pkg.sv
// Shared definitions for the multi-channel clock divider: channel state
// encoding and the reset half-period that matches the legacy fixed ratio.
package multi_channel_clock_divider_pkg;

  // Per-channel run state. Encoding is fixed so it can be observed on the
  // debug state bus and compared against directly.
  typedef enum logic [1:0] {
    CH_IDLE     = 2'd0,
    CH_RUN      = 2'd1,
    CH_STOPPING = 2'd2
  } ch_state_e;

  // Width of one channel's entry on the debug state bus.
  localparam int CH_STATE_W = 2;

  // Half-period loaded at reset; equals the old single-ratio divider.
  localparam int DEFAULT_HALF_VAL = 8001;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: programmable half-period, gated enable with a clean
// stop (the high phase is always completed), one-cycle rising-edge tick,
// and a phase-align input that restarts the channel from a low phase.
//
// Handshake/strobe semantics: load_i and sync_i are single-cycle strobes
// sampled on the rising edge of clk_i; there is no back-pressure, every
// strobe is accepted in the cycle it is presented.
module clk_div_channel
  import multi_channel_clock_divider_pkg::*;
#(
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = DEFAULT_HALF_VAL
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_value_i,
  input  logic             sync_i,
  output logic             out_clk_o,
  output logic             tick_o,
  output logic             running_o,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] half_q,  half_d;
  logic [CNT_W-1:0] pend_q,  pend_d;
  logic             out_q,   out_d;
  logic             tick_q,  tick_d;

  logic [CNT_W-1:0] eff_half;
  logic             terminal;

  // A programmed half-period of zero behaves as one (fastest ratio).
  assign eff_half = (half_q == '0) ? ONE : half_q;
  // half only changes at count 0, so cnt_q never passes eff_half-1.
  assign terminal = (cnt_q == (eff_half - ONE));

  // Next-state logic: idle tracking, counting, toggling, stop and sync.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    pend_d  = load_i ? load_value_i : pend_q;
    out_d   = out_q;
    tick_d  = 1'b0;

    case (state_q)
      CH_IDLE: begin
        // While idle the active ratio follows the pending one, so a load
        // before enabling takes effect on the very first phase.
        cnt_d  = '0;
        out_d  = 1'b0;
        half_d = pend_d;
        if (enable_i) begin
          state_d = CH_RUN;
        end
      end

      CH_RUN, CH_STOPPING: begin
        if (sync_i) begin
          // Phase align wins over everything, including a terminal count.
          cnt_d   = '0;
          out_d   = 1'b0;
          half_d  = pend_q;
          state_d = (state_q == CH_RUN && enable_i) ? CH_RUN : CH_IDLE;
        end else if (state_q == CH_RUN && !enable_i && !out_q) begin
          // Disabled during a low phase: stop at once, no edge produced.
          cnt_d   = '0;
          state_d = CH_IDLE;
        end else if (terminal) begin
          // Phase boundary: toggle, restart count, adopt pending ratio.
          // The old pending value is used even if a load lands now.
          cnt_d  = '0;
          out_d  = ~out_q;
          tick_d = ~out_q;
          half_d = pend_q;
          if (enable_i) begin
            state_d = CH_RUN;
          end else begin
            // Only reachable with out_q high: the stop completes here.
            state_d = CH_IDLE;
          end
        end else begin
          cnt_d = cnt_q + ONE;
          // Disabled with output high: finish the high phase first.
          state_d = enable_i ? CH_RUN : CH_STOPPING;
        end
      end

      default: begin
        // Unused encoding: return to a clean idle.
        state_d = CH_IDLE;
        cnt_d   = '0;
        out_d   = 1'b0;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      half_q  <= RESET_HALF;
      pend_q  <= RESET_HALF;
      out_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign out_clk_o = out_q;
  assign tick_o    = tick_q;
  assign running_o = (state_q != CH_IDLE);
  assign state_o   = state_q;

endmodule

// File: rtl/multi_channel_clock_divider.sv
// Multi-channel programmable clock/tick source. NUM_CH independent divider
// channels share one load port (divLoad/divSel/divValue) and one global
// phase-align strobe. Channel indices at or above NUM_CH are ignored.
// divSel must be wide enough to address every channel (2**SEL_W >= NUM_CH).
module multi_channel_clock_divider
  import multi_channel_clock_divider_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 16,
  parameter int DEFAULT_HALF = DEFAULT_HALF_VAL,
  parameter int SEL_W        = 2
) (
  input  logic                         inClk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            enable,
  input  logic                         divLoad,
  input  logic [SEL_W-1:0]             divSel,
  input  logic [CNT_W-1:0]             divValue,
  input  logic                         phaseSync,
  output logic [NUM_CH-1:0]            outClk,
  output logic [NUM_CH-1:0]            tick,
  output logic [NUM_CH-1:0]            running,
  output logic [CH_STATE_W*NUM_CH-1:0] stateDbg
);

  logic [NUM_CH-1:0] ch_load;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Route the shared load strobe to the addressed channel only.
    assign ch_load[i] = divLoad && (int'(divSel) == i);

    clk_div_channel #(
      .CNT_W        (CNT_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk_i        (inClk),
      .rst_i        (reset),
      .enable_i     (enable[i]),
      .load_i       (ch_load[i]),
      .load_value_i (divValue),
      .sync_i       (phaseSync),
      .out_clk_o    (outClk[i]),
      .tick_o       (tick[i]),
      .running_o    (running[i]),
      .state_o      (stateDbg[CH_STATE_W*i +: CH_STATE_W])
    );
  end

endmodule
